ahfp_div: RTL

//  Multicycle single-precision float divider: result = dataa / datab.

---
 rtl/ahfp_div.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ahfp_div.sv
// Multicycle IEEE-754 single-precision divider (radix-2 restoring), start/done handshake.
// Define AHFP_DIV_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module ahfp_div #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   dataa,
    input  logic [EXP_W+MAN_W:0]   datab,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   done
);

    localparam int unsigned DW = EXP_W + MAN_W + 1;
    localparam int unsigned QW = MAN_W + 3;
    localparam int unsigned CW = $clog2(QW);
    localparam int unsigned EW = EXP_W + 2;

    typedef enum logic [1:0] {StIdle, StCalc, StNorm, StDone} state_t;

    state_t                 state_q;
    logic [DW-2:0]          a_q, b_q;
    logic                   sign_q;
    logic signed [EW-1:0]   exp_q;
    logic [QW-1:0]          q_q;
    logic [MAN_W+1:0]       rem_q;
    logic [CW-1:0]          cnt_q;

    // Restoring step; the first step compares the unshifted dividend mantissa.
    logic [MAN_W+1:0] mb, rem2, rem_nx;
    logic             q_bit;

    always_comb begin
        mb     = {1'b0, 1'b1, b_q[MAN_W-1:0]};
        rem2   = (cnt_q == '0) ? {1'b0, 1'b1, a_q[MAN_W-1:0]} : {rem_q[MAN_W:0], 1'b0};
        q_bit  = (rem2 >= mb);
        rem_nx = q_bit ? (rem2 - mb) : rem2;
    end

    logic [MAN_W-1:0]     frac_n, frac_r;
    logic signed [EW-1:0] exp_n, exp_r;

`ifdef AHFP_DIV_RNE_EN
    logic             guard, sticky, inc;
    logic [MAN_W:0]   frac_sum;

    always_comb begin
        if (q_q[QW-1]) begin
            frac_n = q_q[QW-2:2];
            guard  = q_q[1];
            sticky = q_q[0] | (|rem_q);
            exp_n  = exp_q;
        end else begin
            frac_n = q_q[QW-3:1];
            guard  = q_q[0];
            sticky = |rem_q;
            exp_n  = exp_q - EW'(1);
        end
        inc      = guard & (sticky | frac_n[0]);
        frac_sum = {1'b0, frac_n} + {{MAN_W{1'b0}}, inc};
        frac_r   = frac_sum[MAN_W-1:0];
        exp_r    = frac_sum[MAN_W] ? (exp_n + EW'(1)) : exp_n;
    end
`else
    logic unused_bits;
    assign unused_bits = ^{q_q[0], rem_q};

    always_comb begin
        if (q_q[QW-1]) begin
            frac_n = q_q[QW-2:2];
            exp_n  = exp_q;
        end else begin
            frac_n = q_q[QW-3:1];
            exp_n  = exp_q - EW'(1);
        end
        frac_r = frac_n;
        exp_r  = exp_n;
    end
`endif

    // Operand classification; denormals count as zero.
    logic [EXP_W-1:0] ea, eb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, ovf, unf;
    logic [DW-1:0]    res_n;

    always_comb begin
        ea     = a_q[DW-2:MAN_W];
        eb     = b_q[DW-2:MAN_W];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (a_q[MAN_W-1:0] == '0);
        b_inf  = (eb == '1) && (b_q[MAN_W-1:0] == '0);
        a_nan  = (ea == '1) && (a_q[MAN_W-1:0] != '0);
        b_nan  = (eb == '1) && (b_q[MAN_W-1:0] != '0);
        ovf    = !exp_r[EW-1] && (exp_r[EW-2:0] >= (EW-1)'((1 << EXP_W) - 1));
        unf    = exp_r[EW-1] || (exp_r == '0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (a_inf || b_zero) begin
            res_n = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_inf) begin
            res_n = {sign_q, {(DW-1){1'b0}}};
        end else if (ovf) begin
            res_n = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (unf) begin
            res_n = {sign_q, {(DW-1){1'b0}}};
        end else begin
            res_n = {sign_q, exp_r[EXP_W-1:0], frac_r};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else if (clk_en) begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= dataa[DW-2:0];
                        b_q     <= datab[DW-2:0];
                        sign_q  <= dataa[DW-1] ^ datab[DW-1];
                        exp_q   <= $signed({2'b00, dataa[DW-2:MAN_W]})
                                 - $signed({2'b00, datab[DW-2:MAN_W]})
                                 + $signed(EW'(BIAS));
                        q_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    q_q   <= {q_q[QW-2:0], q_bit};
                    rem_q <= rem_nx;
                    if (cnt_q == CW'(QW - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StNorm;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StNorm: begin
                    result  <= res_n;
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
